// File: rtl/hsv_core_branch_redirect_if.sv
// hsv_core_branch_redirect_if
//   Bundles the signals between the branch unit, commit, fetch and the
//   branch-redirect block. clk_core/rst_core are not part of the bundle.
//
//   Branch unit side : valid_i, in_pc, in_taken, in_target -> ; <- stall_o
//   Commit side      : flush_req, stall_i -> ; <- valid_o, out_pc,
//                      out_next_pc, out_misaligned
//   Pipeline flush   : <- flush_o
//   Fetch side       : redirect_ready -> ; <- redirect_valid, redirect_pc
//
//   Modports:
//     slave  - the redirect block itself (consumes branches, drives records)
//     master - the surrounding pipeline / environment
interface hsv_core_branch_redirect_if;

  logic        flush_req;
  logic        stall_i;
  logic        stall_o;

  logic        valid_i;
  logic [31:0] in_pc;
  logic        in_taken;
  logic [31:0] in_target;

  logic        valid_o;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  logic        out_misaligned;

  logic        flush_o;

  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport slave (
    input  flush_req,
    input  stall_i,
    input  valid_i,
    input  in_pc,
    input  in_taken,
    input  in_target,
    input  redirect_ready,
    output stall_o,
    output valid_o,
    output out_pc,
    output out_next_pc,
    output out_misaligned,
    output flush_o,
    output redirect_valid,
    output redirect_pc
  );

  modport master (
    output flush_req,
    output stall_i,
    output valid_i,
    output in_pc,
    output in_taken,
    output in_target,
    output redirect_ready,
    input  stall_o,
    input  valid_o,
    input  out_pc,
    input  out_next_pc,
    input  out_misaligned,
    input  flush_o,
    input  redirect_valid,
    input  redirect_pc
  );

endinterface

// File: rtl/hsv_core_branch_redirect.sv
// hsv_core_branch_redirect
//   Consumer end of the branch resolution path. Accepts a resolved branch
//   (valid_i/in_pc/in_taken/in_target), produces the committed next-PC
//   record for commit, and on an aligned taken branch flushes younger
//   stages for FLUSH_CYCLES cycles before offering a PC redirect to fetch.
//   The branch unit is stalled (stall_o) while a flush/redirect is running.
//
//   Ports:
//     clk_core  - core clock
//     rst_core  - synchronous active-high reset
//     bus       - hsv_core_branch_redirect_if.slave (branch, commit,
//                 flush and redirect signals)
//
//   Parameters:
//     FLUSH_CYCLES - cycles flush_o is held before the redirect (0..15)
//
//   Optional feature (macro HSV_CORE_BRANCH_STATS_EN):
//     perf_taken         - saturating count of accepted aligned taken branches
//     perf_redirect_wait - saturating count of REDIRECT cycles without
//                          redirect_ready
//     Both clear only on rst_core.
module hsv_core_branch_redirect #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                             clk_core,
  input  logic                             rst_core,
  hsv_core_branch_redirect_if.slave        bus
`ifdef HSV_CORE_BRANCH_STATS_EN
  ,
  output logic [31:0]                      perf_taken,
  output logic [31:0]                      perf_redirect_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t     state;
  logic [3:0] flush_cnt;

  logic       busy;
  logic       accept;
  logic       taken_aligned;
  logic       taken_misaligned;

  always_comb begin
    busy             = (state != IDLE);
    bus.stall_o      = bus.stall_i | busy;
    accept           = bus.valid_i & ~bus.stall_o;
    taken_aligned    = bus.in_taken & (bus.in_target[1:0] == 2'b00);
    taken_misaligned = bus.in_taken & (bus.in_target[1:0] != 2'b00);
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state              <= IDLE;
      flush_cnt          <= '0;
      bus.valid_o        <= 1'b0;
      bus.out_pc         <= '0;
      bus.out_next_pc    <= '0;
      bus.out_misaligned <= 1'b0;
      bus.flush_o        <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else if (bus.flush_req) begin
      // Trap/commit flush wins: any branch offered this cycle is dropped and
      // an in-flight redirect is abandoned (a coincident redirect_ready is
      // simply treated as completed by fetch).
      state              <= IDLE;
      flush_cnt          <= '0;
      bus.valid_o        <= 1'b0;
      bus.flush_o        <= 1'b0;
      bus.redirect_valid <= 1'b0;
    end else begin
      // Commit record: load on acceptance, hold under downstream stall,
      // otherwise retire after one cycle.
      if (accept) begin
        bus.valid_o        <= 1'b1;
        bus.out_pc         <= bus.in_pc;
        bus.out_next_pc    <= bus.in_taken ? bus.in_target : (bus.in_pc + 32'd4);
        bus.out_misaligned <= taken_misaligned;
      end else if (!bus.stall_i) begin
        bus.valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Misaligned taken targets are left for commit to trap on; only
          // aligned ones start the flush/redirect sequence.
          if (accept && taken_aligned) begin
            bus.redirect_pc <= bus.in_target;
            if (FLUSH_CYCLES > 0) begin
              state       <= FLUSH;
              flush_cnt   <= FLUSH_INIT;
              bus.flush_o <= 1'b1;
            end else begin
              state              <= REDIRECT;
              bus.redirect_valid <= 1'b1;
            end
          end
        end

        FLUSH: begin
          if (flush_cnt <= 4'd1) begin
            state              <= REDIRECT;
            flush_cnt          <= '0;
            bus.flush_o        <= 1'b0;
            bus.redirect_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end

        REDIRECT: begin
          if (bus.redirect_ready) begin
            state              <= IDLE;
            bus.redirect_valid <= 1'b0;
          end
        end

        default: begin
          state              <= IDLE;
          flush_cnt          <= '0;
          bus.flush_o        <= 1'b0;
          bus.redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef HSV_CORE_BRANCH_STATS_EN
  // Counters survive flush_req; only reset clears them.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      perf_taken         <= '0;
      perf_redirect_wait <= '0;
    end else begin
      if (!bus.flush_req && accept && taken_aligned && (perf_taken != '1)) begin
        perf_taken <= perf_taken + 32'd1;
      end
      if ((state == REDIRECT) && !bus.redirect_ready && (perf_redirect_wait != '1)) begin
        perf_redirect_wait <= perf_redirect_wait + 32'd1;
      end
    end
  end
`endif

endmodule
